// File: rtl/axi4lite_pkg.sv
// Shared types and address-decode helpers for the AXI4-Lite register slave.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  function automatic logic addr_hit(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int          nregs,
    input int          n
  );
    return (addr >= base) &&
           (addr < base + 64'(nregs) * 64'(n));
  endfunction

  // n is always a power-of-two constant, so this folds to a shift
  function automatic logic [63:0] addr_idx(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int          n
  );
    return (addr - base) / 64'(n);
  endfunction

endpackage

// File: rtl/axi4lite_wr_collect.sv
// One-entry AW and W holding buffers that pair address and data beats
// and emit a single-cycle commit strobe once the B channel is free.
module axi4lite_wr_collect
  import axi4lite_pkg::*;
#(
  parameter int N = 4,
  parameter int A = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           awvalid,
  output logic           awready,
  input  logic [A-1:0]   awaddr,
  input  logic           wvalid,
  output logic           wready,
  input  logic [8*N-1:0] wdata,
  input  logic [N-1:0]   wstrb,
  input  logic           bvalid,
  output logic           commit,
  output logic [A-1:0]   cm_addr,
  output logic [8*N-1:0] cm_data,
  output logic [N-1:0]   cm_strb
);

  logic           aw_full;
  logic           w_full;
  logic [A-1:0]   aw_q;
  logic [8*N-1:0] w_q;
  logic [N-1:0]   s_q;
  logic           aw_hs;
  logic           w_hs;

  assign awready = !rst && !aw_full;
  assign wready  = !rst && !w_full;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // A beat handshaking this edge counts as present, so no bubble
  assign commit = !rst && !bvalid &&
                  (aw_full || aw_hs) &&
                  (w_full || w_hs);

  assign cm_addr = aw_full ? aw_q : awaddr;
  assign cm_data = w_full ? w_q : wdata;
  assign cm_strb = w_full ? s_q : wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_q    <= '0;
      w_q     <= '0;
      s_q     <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_q    <= awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_q    <= wdata;
        s_q    <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite responder over a bank of NREGS byte-strobed registers;
// independent read and write paths, DECERR outside the window.
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int             N     = 4,
  parameter int             A     = 32,
  parameter int             NREGS = 16,
  parameter logic [A-1:0]   BASE  = 'h100
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           AWVALID,
  output logic           AWREADY,
  input  logic [A-1:0]   AWADDR,
  input  logic [2:0]     AWPROT,
  input  logic           WVALID,
  output logic           WREADY,
  input  logic [8*N-1:0] WDATA,
  input  logic [N-1:0]   WSTRB,
  output logic           BVALID,
  input  logic           BREADY,
  output logic [1:0]     BRESP,
  input  logic           ARVALID,
  output logic           ARREADY,
  input  logic [A-1:0]   ARADDR,
  input  logic [2:0]     ARPROT,
  output logic           RVALID,
  input  logic           RREADY,
  output logic [8*N-1:0] RDATA,
  output logic [1:0]     RRESP
);

  localparam int DW = 8 * N;
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DW-1:0] regs [NREGS];

  logic          commit;
  logic [A-1:0]  cm_addr;
  logic [DW-1:0] cm_data;
  logic [N-1:0]  cm_strb;

  logic          bvalid_q;
  resp_t         bresp_q;
  logic          rvalid_q;
  resp_t         rresp_q;
  logic [DW-1:0] rdata_q;

  logic [63:0]   w_idx_full;
  logic [63:0]   r_idx_full;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] r_idx;
  logic          w_hit;
  logic          r_hit;
  logic          ar_hs;
  logic          unused_ok;

  axi4lite_wr_collect #(
    .N(N),
    .A(A)
  ) u_wr (
    .clk     (Clk),
    .rst     (Rst),
    .awvalid (AWVALID),
    .awready (AWREADY),
    .awaddr  (AWADDR),
    .wvalid  (WVALID),
    .wready  (WREADY),
    .wdata   (WDATA),
    .wstrb   (WSTRB),
    .bvalid  (bvalid_q),
    .commit  (commit),
    .cm_addr (cm_addr),
    .cm_data (cm_data),
    .cm_strb (cm_strb)
  );

  assign w_hit      = addr_hit(64'(cm_addr), 64'(BASE), NREGS, N);
  assign w_idx_full = addr_idx(64'(cm_addr), 64'(BASE), N);
  assign w_idx      = w_idx_full[IW-1:0];

  assign r_hit      = addr_hit(64'(ARADDR), 64'(BASE), NREGS, N);
  assign r_idx_full = addr_idx(64'(ARADDR), 64'(BASE), N);
  assign r_idx      = r_idx_full[IW-1:0];

  assign unused_ok = ^{AWPROT, ARPROT,
                       w_idx_full[63:IW],
                       r_idx_full[63:IW]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit && w_hit) begin
      for (int b = 0; b < N; b++)
        if (cm_strb[b])
          regs[w_idx][8*b +: 8] <= cm_data[8*b +: 8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= w_hit ? OKAY : DECERR;
    end else if (bvalid_q && BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  assign ARREADY = !Rst && !rvalid_q;
  assign ar_hs   = ARVALID && ARREADY;

  // Same-edge write to the same register is not forwarded: old value returns
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= r_hit ? OKAY : DECERR;
      rdata_q  <= r_hit ? regs[r_idx] : '0;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RRESP  = rresp_q;
  assign RDATA  = rdata_q;

endmodule
